// File: rtl/gigatron_ram_pipe.sv
// Simple-dual-port RAM with a 1..3 cycle read pipeline, write-first
// forwarding on same-cycle collisions and an optional zero-fill sweep
// that runs after every reset.
module gigatron_ram_pipe #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int RAM_SIZE       = 65536,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  // Clamped so an illegal setting still elaborates far enough to report it.
  localparam int LAT   = (READ_LATENCY < 1) ? 1 :
                         (READ_LATENCY > 3) ? 3 : READ_LATENCY;
  localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH+1)'(RAM_SIZE);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(RAM_SIZE - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 3 || RAM_SIZE < 1 ||
      longint'(RAM_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_param_check
    $error("gigatron_ram_pipe: illegal READ_LATENCY or RAM_SIZE");
  end

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

  logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

  logic                  wr_in_range, rd_in_range;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_result;

  logic [LAT-1:0]        pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [LAT];

  assign wr_in_range = ({1'b0, i_waddr} < SIZE_EXT);
  assign rd_in_range = ({1'b0, i_raddr} < SIZE_EXT);
  assign rd_fire     = (state == S_RUN) && i_re;

  // State and sweep counter; reset restarts the sweep from address 0.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Sweep advances one word per cycle and leaves CLEAR after the last word.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) state_nxt = S_RUN;
      end
      S_RUN:   ;
      default: state_nxt = S_RUN;
    endcase
  end

  // Single array write port, shared between the sweep and the user port.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = clr_cnt;
    mem_wd = '0;
    if (state == S_CLEAR) begin
      mem_we = 1'b1;
    end else if (i_we && wr_in_range) begin
      mem_we = 1'b1;
      mem_wa = i_waddr[IDX_W-1:0];
      mem_wd = i_data;
    end
  end

  // Array storage; deliberately untouched by reset.
  always_ff @(posedge i_clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read result chosen at issue: forwarded write data, zero, or old word.
  always_comb begin
    rd_result = '0;
    if (rd_in_range) begin
      if (i_we && wr_in_range && (i_waddr == i_raddr)) rd_result = i_data;
      else                                             rd_result = mem[i_raddr[IDX_W-1:0]];
    end
  end

  // Read pipeline; data stages load only with a valid so the last stage
  // holds the most recent result while o_valid is low.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < LAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_fire;
      if (rd_fire) pipe_data[0] <= rd_result;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign o_valid = pipe_valid[LAT-1];
  assign o_data  = pipe_data[LAT-1];
  assign o_busy  = (state == S_CLEAR);

endmodule

// File: tb/tb_gigatron_ram_pipe.sv
// Directed bench for gigatron_ram_pipe: five instances with different
// latency / size / clear settings share one stimulus stream.
module tb_gigatron_ram_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] raddr, waddr;
  logic        re, we;
  logic [7:0]  wdata;

  logic [7:0] a_data, b_data, c_data, d_data, e_data;
  logic       a_valid, b_valid, c_valid, d_valid, e_valid;
  logic       a_busy, b_busy, c_busy, d_busy, e_busy;

  int passed = 0;
  int total  = 0;
  int n;
  int bad;
  int vcnt;
  logic vflag;

  always #5 clk = ~clk;

  // a: latency 1, 256 words, cleared
  gigatron_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_SIZE(256),
                      .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_raddr(raddr), .i_re(re),
    .i_waddr(waddr), .i_we(we), .i_data(wdata),
    .o_data(a_data), .o_valid(a_valid), .o_busy(a_busy));

  // b: latency 2
  gigatron_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_SIZE(256),
                      .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_raddr(raddr), .i_re(re),
    .i_waddr(waddr), .i_we(we), .i_data(wdata),
    .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy));

  // c: latency 3
  gigatron_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_SIZE(256),
                      .READ_LATENCY(3), .CLEAR_ON_RESET(1)) dut_c (
    .i_clock(clk), .i_reset_n(rst_n), .i_raddr(raddr), .i_re(re),
    .i_waddr(waddr), .i_we(we), .i_data(wdata),
    .o_data(c_data), .o_valid(c_valid), .o_busy(c_busy));

  // d: 200 words, exercises out-of-range handling
  gigatron_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_SIZE(200),
                      .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_d (
    .i_clock(clk), .i_reset_n(rst_n), .i_raddr(raddr), .i_re(re),
    .i_waddr(waddr), .i_we(we), .i_data(wdata),
    .o_data(d_data), .o_valid(d_valid), .o_busy(d_busy));

  // e: no clear sweep, contents retained over reset
  gigatron_ram_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_SIZE(256),
                      .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_e (
    .i_clock(clk), .i_reset_n(rst_n), .i_raddr(raddr), .i_re(re),
    .i_waddr(waddr), .i_we(we), .i_data(wdata),
    .o_data(e_data), .o_valid(e_valid), .o_busy(e_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    tick(); tick();

    check("rst_a_valid", a_valid, 0);
    check("rst_a_data",  a_data,  0);
    check("rst_a_busy",  a_busy,  1);
    check("rst_e_busy",  e_busy,  0);

    // Sweep with requests pending, interrupted at count 100.
    rst_n = 1'b1; re = 1'b1; raddr = 16'h0005;
    we = 1'b1; waddr = 16'h0005; wdata = 8'hEE;
    vflag = 1'b0;
    repeat (100) begin
      tick();
      if (a_valid || b_valid || c_valid) vflag = 1'b1;
    end
    check("busy_at_100", a_busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",    a_busy,  1);
    check("midrst_c_valid", c_valid, 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    while (a_busy && n < 1000) begin
      tick();
      n++;
      if (a_valid || b_valid || c_valid) vflag = 1'b1;
    end
    check("sweep_len",       n,     256);
    check("no_valid_in_clr", vflag, 0);
    we = 1'b0; re = 1'b0;
    tick();

    // Whole array reads back as zero (address 5 included).
    re = 1'b1; bad = 0; vcnt = 0;
    for (int i = 0; i < 256; i++) begin
      raddr = 16'(i);
      tick();
      if (a_valid) vcnt++;
      if (a_data !== 8'h00) bad++;
    end
    re = 1'b0;
    check("zero_valid_cnt", vcnt, 256);
    check("zero_bad_cnt",   bad,  0);
    tick();

    // Basic write then read, latency 1.
    we = 1'b1; waddr = 16'h0010; wdata = 8'hA5;
    tick();
    we = 1'b0; re = 1'b1; raddr = 16'h0010;
    tick();
    check("basic_valid", a_valid, 1);
    check("basic_data",  a_data,  8'hA5);
    re = 1'b0;
    tick();
    check("basic_vdrop", a_valid, 0);
    check("basic_hold",  a_data,  8'hA5);

    // Collision forwarding and in-flight isolation.
    we = 1'b1; waddr = 16'h0042; wdata = 8'h11;
    tick();
    wdata = 8'h22; re = 1'b1; raddr = 16'h0042;
    tick();
    check("coll_b_early", b_valid, 0);
    check("coll_a_data",  a_data,  8'h22);
    we = 1'b0;
    tick();
    check("coll_b_valid", b_valid, 1);
    check("coll_b_data",  b_data,  8'h22);
    re = 1'b0; we = 1'b1; wdata = 8'h33;
    tick();
    check("inflight_b_valid", b_valid, 1);
    check("inflight_b_data",  b_data,  8'h22);
    we = 1'b0;
    tick();
    check("b_vdrop", b_valid, 0);
    check("b_hold",  b_data,  8'h22);

    // Back-to-back reads through the 3-stage pipeline.
    we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      waddr = 16'(i); wdata = 8'(8'h80 + i);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 11; k++) begin
      re = (k < 8); raddr = 16'(k);
      tick();
      check("pipe_valid", c_valid, (k >= 2 && k <= 9) ? 1 : 0);
      if (k >= 2 && k <= 9) check("pipe_data", c_data, 8'h80 + 8'(k - 2));
    end
    re = 1'b0;

    // Range handling on the 200-word instance.
    we = 1'b1; waddr = 16'd250; wdata = 8'h5A;
    tick();
    waddr = 16'd199; wdata = 8'h77;
    tick();
    we = 1'b0; re = 1'b1; raddr = 16'd250;
    tick();
    check("oor_d_valid", d_valid, 1);
    check("oor_d_data",  d_data,  0);
    check("inr_a_data",  a_data,  8'h5A);
    raddr = 16'd199;
    tick();
    check("edge_d_199", d_data, 8'h77);
    raddr = 16'd200;
    tick();
    check("oor_d_200", d_data, 0);
    we = 1'b1; waddr = 16'd250; wdata = 8'h66; raddr = 16'd250;
    tick();
    check("oor_coll_d", d_data, 0);
    check("coll_a_250", a_data, 8'h66);
    we = 1'b0; re = 1'b0;
    tick();

    // Retention across reset without a sweep.
    rst_n = 1'b0;
    #1;
    check("ret_e_busy",  e_busy,  0);
    check("ret_e_valid", e_valid, 0);
    check("ret_e_data",  e_data,  0);
    check("ret_a_busy",  a_busy,  1);
    tick();
    rst_n = 1'b1; re = 1'b1; raddr = 16'h0010;
    tick();
    check("ret_e_valid1", e_valid, 1);
    check("ret_e_10",     e_data,  8'hA5);
    check("ret_a_novalid", a_valid, 0);
    raddr = 16'h0042;
    tick();
    check("ret_e_42", e_data, 8'h33);
    raddr = 16'd250;
    tick();
    check("ret_e_250", e_data, 8'h66);
    raddr = 16'd3;
    tick();
    check("ret_e_3", e_data, 8'h83);
    re = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
